// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex UART with a 16x oversampled transmitter and receiver.
// Both directions share clk_i and one baud divisor (bit = 16*baud_rate_i clocks).
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   baud_rate_i         clocks per oversample tick (0 is treated as 1)
//   tx_data_i/start_i   word to send and its start request
//   tx_o                serial output, idle high
//   tx_busy_o/done_o    frame in progress / last-cycle-of-frame pulse
//   rx_i                asynchronous serial input
//   rx_data_o           last received word
//   rx_parity_error_o   parity status of last frame
//   rx_frame_error_o    stop bit sampled low in last frame
//   rx_done_o           one-cycle pulse per received frame
//
// Build option: define UART_LOOPBACK_EN to feed the receiver from tx_o
// instead of rx_i.

module uart_txrx #(
  parameter int    MAX_WIDTH     = 32,
  parameter int    DATA_WIDTH    = 8,
  parameter int    NUM_STOP_BITS = 1,
  parameter string PARITY_MODE   = "EVEN"
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [MAX_WIDTH-1:0]  baud_rate_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_start_i,
  output logic                  tx_o,
  output logic                  tx_busy_o,
  output logic                  tx_done_o,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_parity_error_o,
  output logic                  rx_frame_error_o,
  output logic                  rx_done_o
);

  localparam bit PAR_EN  = (PARITY_MODE != "NONE");
  localparam bit PAR_ODD = (PARITY_MODE == "ODD");
  localparam int IW      = $clog2(DATA_WIDTH);

  localparam logic [IW-1:0] LAST_IDX =
    IW'(DATA_WIDTH - 1);
  localparam logic LAST_STOP =
    1'(NUM_STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [MAX_WIDTH-1:0] div_eff;

  assign div_eff = (baud_rate_i == '0) ?
                   MAX_WIDTH'(1) : baud_rate_i;

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  state_t                tx_state;
  logic [MAX_WIDTH-1:0]  tx_div;
  logic [MAX_WIDTH-1:0]  tx_cnt;
  logic [3:0]            tx_sub;
  logic [IW-1:0]         tx_idx;
  logic                  tx_stop;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic                  tx_par;

  logic tx_tick;
  logic tx_bit_end;
  logic tx_last_stop;
  logic tx_pre_end;

  always_comb begin
    tx_tick      = (tx_cnt == tx_div - MAX_WIDTH'(1));
    tx_bit_end   = tx_tick && (tx_sub == 4'd15);
    tx_last_stop = (tx_state == S_STOP) &&
                   (tx_stop == LAST_STOP);
    // True one cycle before the final clock of the frame, so the
    // registered done pulse lands exactly on that final clock.
    tx_pre_end   = tx_last_stop && (
      ((tx_sub == 4'd15) &&
       (tx_cnt == tx_div - MAX_WIDTH'(2))) ||
      ((tx_div == MAX_WIDTH'(1)) &&
       (tx_sub == 4'd14)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state  <= S_IDLE;
      tx_o      <= 1'b1;
      tx_busy_o <= 1'b0;
      tx_done_o <= 1'b0;
      tx_div    <= MAX_WIDTH'(1);
      tx_cnt    <= '0;
      tx_sub    <= '0;
      tx_idx    <= '0;
      tx_stop   <= 1'b0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      if (tx_state == S_IDLE) begin
        if (tx_start_i) begin
          tx_state  <= S_START;
          tx_o      <= 1'b0;
          tx_busy_o <= 1'b1;
          tx_div    <= div_eff;
          tx_cnt    <= '0;
          tx_sub    <= '0;
          tx_idx    <= '0;
          tx_stop   <= 1'b0;
          tx_sh     <= tx_data_i;
          tx_par    <= (^tx_data_i) ^ PAR_ODD;
        end
      end else begin
        tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
        if (tx_tick) begin
          tx_sub <= tx_sub + 4'd1;
        end
        if (tx_pre_end) begin
          tx_done_o <= 1'b1;
        end
        if (tx_bit_end) begin
          unique case (tx_state)
            S_START: begin
              tx_state <= S_DATA;
              tx_o     <= tx_sh[0];
            end
            S_DATA: begin
              if (tx_idx == LAST_IDX) begin
                if (PAR_EN) begin
                  tx_state <= S_PARITY;
                  tx_o     <= tx_par;
                end else begin
                  tx_state <= S_STOP;
                  tx_o     <= 1'b1;
                end
              end else begin
                tx_idx <= tx_idx + 1'b1;
                tx_sh  <= tx_sh >> 1;
                tx_o   <= tx_sh[1];
              end
            end
            S_PARITY: begin
              tx_state <= S_STOP;
              tx_o     <= 1'b1;
            end
            S_STOP: begin
              if (tx_last_stop) begin
                tx_state  <= S_IDLE;
                tx_busy_o <= 1'b0;
              end else begin
                tx_stop <= 1'b1;
              end
              tx_o <= 1'b1;
            end
            default: begin
              tx_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  logic rx_line;

`ifdef UART_LOOPBACK_EN
  assign rx_line = tx_o | (rx_i & 1'b0);
`else
  assign rx_line = rx_i;
`endif

  logic [1:0] rx_sync;
  logic       rx_s;

  assign rx_s = rx_sync[1];

  state_t                rx_state;
  logic [MAX_WIDTH-1:0]  rx_div;
  logic [MAX_WIDTH-1:0]  rx_cnt;
  logic [3:0]            rx_sub;
  logic [IW-1:0]         rx_idx;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  rx_pbit;
  logic                  rx_armed;

  logic rx_tick;
  logic rx_mid;

  always_comb begin
    rx_tick = (rx_cnt == rx_div - MAX_WIDTH'(1));
    rx_mid  = rx_tick && (rx_sub == 4'd15);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx_line};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state          <= S_IDLE;
      rx_div            <= MAX_WIDTH'(1);
      rx_cnt            <= '0;
      rx_sub            <= '0;
      rx_idx            <= '0;
      rx_sh             <= '0;
      rx_pbit           <= 1'b0;
      rx_armed          <= 1'b0;
      rx_data_o         <= '0;
      rx_parity_error_o <= 1'b0;
      rx_frame_error_o  <= 1'b0;
      rx_done_o         <= 1'b0;
    end else begin
      rx_done_o <= 1'b0;
      if (rx_state == S_IDLE) begin
        // A start is only taken after the line has been seen high,
        // so a low stop bit cannot re-trigger a phantom frame.
        rx_armed <= rx_armed | rx_s;
        if (rx_armed && !rx_s) begin
          rx_state <= S_START;
          rx_div   <= div_eff;
          rx_cnt   <= '0;
          rx_sub   <= '0;
          rx_idx   <= '0;
        end
      end else begin
        rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
        if (rx_tick) begin
          rx_sub <= rx_sub + 4'd1;
        end
        unique case (rx_state)
          S_START: begin
            if (rx_tick && (rx_sub == 4'd7)) begin
              rx_sub <= '0;
              if (rx_s) begin
                rx_state <= S_IDLE;
              end else begin
                rx_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_mid) begin
              rx_sh  <= {rx_s, rx_sh[DATA_WIDTH-1:1]};
              rx_idx <= rx_idx + 1'b1;
              if (rx_idx == LAST_IDX) begin
                rx_state <= PAR_EN ? S_PARITY : S_STOP;
              end
            end
          end
          S_PARITY: begin
            if (rx_mid) begin
              rx_pbit  <= rx_s;
              rx_state <= S_STOP;
            end
          end
          S_STOP: begin
            if (rx_mid) begin
              rx_data_o         <= rx_sh;
              rx_parity_error_o <= PAR_EN &&
                (((^rx_sh) ^ rx_pbit) != PAR_ODD);
              rx_frame_error_o  <= ~rx_s;
              rx_done_o         <= 1'b1;
              rx_armed          <= rx_s;
              rx_state          <= S_IDLE;
            end
          end
          default: begin
            rx_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: randomized scoreboard bench for uart_txrx.
// Loopback is done externally by routing tx_o back onto rx_i.

module tb_uart_txrx;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] baud_rate_i;
  logic [7:0]  tx_data_i;
  logic        tx_start_i;
  logic        tx_o;
  logic        tx_busy_o;
  logic        tx_done_o;
  logic        rx_line;
  logic [7:0]  rx_data_o;
  logic        rx_parity_error_o;
  logic        rx_frame_error_o;
  logic        rx_done_o;

  logic loop_sel;
  logic rx_drv;

  assign rx_line = loop_sel ? tx_o : rx_drv;

  always #5 clk = ~clk;

  uart_txrx dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .baud_rate_i       (baud_rate_i),
    .tx_data_i         (tx_data_i),
    .tx_start_i        (tx_start_i),
    .tx_o              (tx_o),
    .tx_busy_o         (tx_busy_o),
    .tx_done_o         (tx_done_o),
    .rx_i              (rx_line),
    .rx_data_o         (rx_data_o),
    .rx_parity_error_o (rx_parity_error_o),
    .rx_frame_error_o  (rx_frame_error_o),
    .rx_done_o         (rx_done_o)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int last_tx_done_cyc = 0;
  int last_rx_done_cyc = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Reference: parity of data plus parity bit must be even.
  function automatic logic even_par(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2) == 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every received frame.
  always @(negedge clk) begin
    if (tx_done_o) begin
      tx_done_cnt++;
      last_tx_done_cyc = cyc;
    end
    if (rx_done_o) begin
      rx_done_cnt++;
      last_rx_done_cyc = cyc;
      if (q.size() == 0) begin
        chk("rx_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("rx_data", 32'(rx_data_o), 32'(mon_e.d));
        chk("rx_perr", 32'(rx_parity_error_o),
            32'(mon_e.pe));
        chk("rx_ferr", 32'(rx_frame_error_o),
            32'(mon_e.fe));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    while (tx_busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle", 32'(tx_busy_o), 32'd0);
  endtask

  task automatic wait_rx_drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rx_drain", 32'(q.size()), 32'd0);
  endtask

  task automatic send_tx(input logic [7:0] d,
                         input int b);
    exp_t e;
    wait_tx_idle(50000);
    @(negedge clk);
    baud_rate_i = 32'(b);
    tx_data_i   = d;
    tx_start_i  = 1'b1;
    if (loop_sel) begin
      e.d  = d;
      e.pe = 1'b0;
      e.fe = 1'b0;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    tx_start_i = 1'b0;
    chk("tx_busy_rise", 32'(tx_busy_o), 32'd1);
    chk("tx_start_bit", 32'(tx_o), 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] d,
                             input logic pbit,
                             input logic sbit,
                             input int b);
    loop_sel    = 1'b0;
    baud_rate_i = 32'(b);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (16 * b) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (16 * b) @(negedge clk);
    end
    rx_drv = pbit;
    repeat (16 * b) @(negedge clk);
    rx_drv = sbit;
    repeat (16 * b) @(negedge clk);
    rx_drv = 1'b1;
    repeat (32 * b) @(negedge clk);
  endtask

  int bauds[6] = '{0, 1, 2, 3, 4, 7};

  initial begin
    exp_t e;
    logic [7:0] d;
    int b0;
    int rd;
    rst_i       = 1'b1;
    baud_rate_i = 32'd66;
    tx_data_i   = 8'h00;
    tx_start_i  = 1'b0;
    loop_sel    = 1'b1;
    rx_drv      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_o", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(tx_busy_o), 32'd0);
    chk("rst_tx_done", 32'(tx_done_o), 32'd0);
    chk("rst_rx_data", 32'(rx_data_o), 32'd0);
    chk("rst_perr", 32'(rx_parity_error_o), 32'd0);
    chk("rst_ferr", 32'(rx_frame_error_o), 32'd0);
    chk("rst_rx_done", 32'(rx_done_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);

    // Single loopback frame at 66 clocks per tick.
    send_tx(8'hA5, 66);
    wait_tx_idle(20000);
    chk("frame_len", 32'(last_tx_done_cyc - start_cyc),
        32'(176 * 66 - 1));
    chk("rx_before_tx",
        32'(last_rx_done_cyc < last_tx_done_cyc), 32'd1);
    wait_rx_drain(2000);
    chk("tx_done_cnt1", 32'(tx_done_cnt), 32'd1);

    // Ten random bytes back-to-back, varying baud.
    b0 = tx_done_cnt;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      send_tx(d, bauds[$urandom_range(0, 5)]);
      if (i == 4) begin
        repeat (100) @(negedge clk);
        tx_data_i  = ~d;
        tx_start_i = 1'b1;
        @(negedge clk);
        tx_start_i = 1'b0;
        chk("busy_hold", 32'(tx_busy_o), 32'd1);
      end
    end
    wait_tx_idle(5000);
    wait_rx_drain(5000);
    chk("tx_done_cnt10", 32'(tx_done_cnt - b0), 32'd10);

    // Parity bit flipped on 0x0F.
    e.d  = 8'h0F;
    e.pe = 1'b1 ^ even_par(8'h0F) ^ 1'b0;
    e.fe = 1'b0;
    e.pe = (even_par(8'h0F) != 1'b1);
    q.push_back(e);
    drive_frame(8'h0F, 1'b1, 1'b1, 66);
    wait_rx_drain(2000);

    // Short low glitch on idle line.
    rd = rx_done_cnt;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3 * 66) @(negedge clk);
    rx_drv = 1'b1;
    repeat (32 * 66) @(negedge clk);
    chk("glitch_no_done", 32'(rx_done_cnt), 32'(rd));

    // Stop bit low on 0x3C with correct parity.
    e.d  = 8'h3C;
    e.pe = 1'b0;
    e.fe = 1'b1;
    q.push_back(e);
    drive_frame(8'h3C, even_par(8'h3C), 1'b0, 66);
    wait_rx_drain(2000);

    // Reset during data bit 4 of a transmission.
    loop_sel = 1'b0;
    rx_drv   = 1'b1;
    send_tx(8'h5A, 66);
    repeat (88 * 66) @(negedge clk);
    chk("mid_busy", 32'(tx_busy_o), 32'd1);
    rd = tx_done_cnt;
    b0 = rx_done_cnt;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx_o", 32'(tx_o), 32'd1);
    chk("abort_busy", 32'(tx_busy_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (8 * 1056) @(negedge clk);
    chk("abort_no_tx_done", 32'(tx_done_cnt), 32'(rd));
    chk("abort_no_rx_done", 32'(rx_done_cnt), 32'(b0));
    chk("abort_idle", 32'(tx_busy_o), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

Full-duplex UART block pairing an oversampled transmitter and receiver on one clock and one shared baud divisor. The transmitter serialises a parallel word into a start/data/parity/stop frame. The receiver recovers frames from a serial line using 16x oversampling with mid-bit sampling. It sits between a host register interface and the chip's serial pins.

## Interface
- MAX_WIDTH, 32: width of baud divisor input.
- DATA_WIDTH, 8: data bits per frame (5..9).
- NUM_STOP_BITS, 1: stop bits per frame (1 or 2).
- PARITY_MODE, "EVEN": "NONE", "EVEN" or "ODD".

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- baud_rate_i  in  MAX_WIDTH  clocks per oversample tick; bit period = 16*baud_rate_i clocks.
- tx_data_i  in  DATA_WIDTH  word to transmit.
- tx_start_i  in  1  start request.
- tx_o  out  1  serial output; idle high.
- tx_busy_o  out  1  high while a frame is being sent.
- tx_done_o  out  1  one-cycle pulse at end of last stop bit.
- rx_i  in  1  serial input (asynchronous).
- rx_data_o  out  DATA_WIDTH  last received word.
- rx_parity_error_o  out  1  parity status of last frame.
- rx_frame_error_o  out  1  stop bit sampled low in last frame.
- rx_done_o  out  1  one-cycle pulse when a frame is received.

## Operation
- Tick generator: a counter per direction counts 0..baud_rate_i-1 and asserts one tick on wrap. baud_rate_i = 0 is treated as 1. Each bit lasts 16 ticks.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o = 1. tx_start_i high captures tx_data_i and baud_rate_i, then moves to START.
  - START: tx_o = 0 for one bit.
  - DATA: sends DATA_WIDTH bits, LSB first.
  - PARITY: sends the parity bit; skipped if "NONE". EVEN means the data bits plus the parity bit have an even number of ones. ODD means they have an odd number.
  - STOP: sends NUM_STOP_BITS high bits. tx_done_o pulses, then the FSM returns to IDLE.
- tx_start_i is ignored while tx_busy_o is high.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - rx_i passes through a 2-flop synchroniser, reset to 1.
  - IDLE: a synchronised low moves to START. The tick counter is aligned to this edge.
  - START: after 8 ticks rx is resampled. If high, it was a false start: return to IDLE with no outputs changed.
  - DATA and PARITY: each bit is sampled every 16 ticks at mid-bit. Data is assembled LSB first.
  - STOP: samples the first stop bit only. rx_data_o, rx_parity_error_o and rx_frame_error_o update, and rx_done_o pulses. All of these happen in the same cycle as the first stop-bit sample.
  - After STOP the FSM returns to IDLE and waits for rx high before detecting the next start.
- rx_data_o and both error flags hold their values until the next completed frame.
- rx_parity_error_o is always 0 in "NONE" mode.

## Timing
- Reset values:
  - tx_o = 1; tx_busy_o, tx_done_o = 0.
  - rx_data_o = 0; all rx flags = 0.
  - Both FSMs in IDLE; counters at 0.
- TX latency:
  - tx_o falls on the cycle after tx_start_i is sampled, and tx_busy_o rises in the same cycle.
  - Frame length = (1+DATA_WIDTH+P+NUM_STOP_BITS)*16*baud_rate_i clocks, where P = 1 if parity is enabled, else 0.
  - tx_done_o pulses on the last cycle of the frame. tx_busy_o falls on the next cycle, and a new start is accepted from that cycle.
- RX latency: rx_done_o pulses about (1+DATA_WIDTH+P)*16*B + 8*B + 3 clocks after the falling edge of rx_i, where B = baud_rate_i. In loopback it always comes before tx_done_o.
- A new baud_rate_i value takes effect only at the next frame start.
- rst_i mid-frame aborts both FSMs immediately. tx_o returns high in the next cycle and no done pulse is produced.

## Configuration
- UART_LOOPBACK_EN:
  - Defined: the receiver input is driven internally from tx_o and rx_i is ignored.
  - Undefined: the receiver uses rx_i.

## Test plan
- Loopback, baud_rate_i=66, EVEN, 1 stop; send 0xA5 -> rx_done_o pulses, rx_data_o=0xA5, no errors. The frame lasts 176*66 clocks.
- Ten random bytes back-to-back in loopback -> every rx_data_o matches its byte with zero errors, and tx_done_o is seen 10 times.
- Parity flip: drive rx_i with 0x0F and parity bit 1 (EVEN) -> rx_parity_error_o=1, rx_data_o=0x0F.
- Glitch: 3*66-clock low pulse on an idle rx_i -> no rx_done_o; receiver stays in IDLE.
- Stop bit driven low on a 0x3C frame -> rx_frame_error_o=1, rx_data_o=0x3C.
- Assert rst_i during bit 4 of a transmission -> tx_o=1 and tx_busy_o=0 next cycle, with no done pulse.
